vga_campos_texto: RTL and testbench
===================================

// Module: vga_campos_texto
// PURPOSE
//  Parametrised text-field renderer for the VGA clock display. Draws NUM_CAMPOS two-digit BCD
//  fields (hh:mm:ss, dd/mm/aa, chrono) as one text row from external font ROM glyphs.
//  Per-field edit cursor blinks red; alarm ring flashes all fields. Sits between the VGA sync
//  generator and the RGB pins; delays hsync/vsync to match its 3-cycle pixel pipeline.
// PARAMETERS
//  NUM_CAMPOS  9            number of 2-digit fields (1..16)
//  ORIGEN_X    64           left pixel of row; multiple of 8 (elaboration error otherwise)
//  ORIGEN_Y    128          top pixel of row
//  BLINK_DIV   25_000_000   CLK cycles per blink half-period (>=2)
//  COLOR_NORM  3'b010       digit colour, idle field
//  COLOR_CUR   3'b100       digit colour, cursor field
//  COLOR_RING  3'b110       digit colour, non-cursor fields, ring phase
// PORTS
//  CLK         in   1              system clock; one clock domain
//  RESET       in   1              reset, synchronous, active-high
//  video_on    in   1              visible-area flag from sync generator
//  pixel_x     in   10             current pixel column
//  pixel_y     in   10             current pixel row
//  h_sync_in   in   1              hsync from sync generator
//  v_sync_in   in   1              vsync from sync generator
//  digitos     in   8*NUM_CAMPOS   field i = digitos[8i+7:8i]; high nibble = tens, BCD
//  bandera     in   NUM_CAMPOS     cursor flag per field (edit mode)
//  activring   in   1              alarm ringing
//  rom_addr    out  11             {char_code[6:0], glyph_row[3:0]} to font ROM
//  rom_data    in   8              glyph row; sync ROM, valid 1 cycle after rom_addr
//  h_sync      out  1              h_sync_in delayed 3 cycles
//  v_sync      out  1              v_sync_in delayed 3 cycles
//  text_on     out  1              pixel belongs to a lit glyph
//  text_rgb    out  3              pixel colour
// BEHAVIOUR
//  - Reset: rom_addr=0, text_on=0, text_rgb=0, h_sync=v_sync=1, all pipeline regs 0, blink cnt=0, phase=0.
//  - Geometry: 8x16 glyphs; each field = 3 char cells (tens, units, separator). Region
//    x in [ORIGEN_X, ORIGEN_X+24*NUM_CAMPOS), y in [ORIGEN_Y, ORIGEN_Y+16).
//    col=(x-ORIGEN_X)>>3; field=col/3, slot=col%3 via compare chain/counter, no '/' operator.
//  - Char codes: digit d<=9 -> 7'h30+d; nibble >9 -> 7'h20 (blank); slot 2 -> 7'h3A ':'
//    except last field -> 7'h20. glyph_row = pixel_y-ORIGEN_Y (4 bits).
//  - Pipeline: cycle k coords -> edge k+1 rom_addr + metadata (field, x[2:0], in_region, video_on)
//    -> edge k+2 ROM registers; metadata shifted -> edge k+3 text_on/text_rgb and syncs.
//    Latency exactly 3 cycles for every pixel; no stalls, one pixel per cycle.
//  - bit = rom_data[7-x[2:0]]. text_on = video_on & in_region & bit & !blanked.
//  - Colour (when text_on): cursor field -> COLOR_CUR; else activring & phase=1 -> COLOR_RING;
//    else COLOR_NORM. text_on=0 -> text_rgb=3'b000.
//  - Cursor blink: field with bandera=1 blanked (text_on=0) while phase=1; visible red while phase=0.
//    Several bandera bits set: each flagged field blinks independently, same phase.
//  - Blink gen: counter 0..BLINK_DIV-1, phase toggles on wrap. Any 0->1 edge on any bandera bit
//    restarts counter to 0 and phase to 0 (new cursor visible immediately).
//    Simultaneous wrap and restart: restart wins.
//  - activring with no bandera: all fields alternate NORM/RING per phase; cursor wins on overlap.
//  - Outside region or video_on=0: text_on=0, rgb=0; rom_addr still driven (don't-care value).
//  - RESET mid-frame: outputs zero next edge; pipeline refills, first valid pixel 3 cycles after release.
// STRUCTURE
//  - Shared package/header: char codes (CHR_0, CHR_COLON, CHR_BLANK), glyph dims (8,16),
//    colour constants, rom_addr field widths.
//  - Sub-module vga_parpadeo: blink counter + phase + bandera edge restart (param BLINK_DIV).
//  - Top: field/slot decode, 3-stage pixel + sync delay pipeline, colour mux.
// TESTING (BLINK_DIV=8, NUM_CAMPOS=3, ORIGEN_X=64, ORIGEN_Y=128, ROM model returns 8'hFF for 7'h38)
//  - RESET 1 for 2 cycles -> text_on=0, rgb=0, h_sync=v_sync=1; released -> first valid output 3 cycles later.
//  - digitos=24'h000088, video_on=1, x=64..71,y=130 -> rom_addr={7'h38,4'd2}; 3 cycles later text_on=1, rgb=010 each pixel.
//  - x=63 or x=136 or y=144 -> text_on=0, rgb=000; x=80,y=128 -> rom_addr={7'h3A,4'd0}.
//  - digit nibble 4'hC -> rom_addr char 7'h20; last field slot 2 -> 7'h20.
//  - bandera=3'b001 rising -> phase 0, field0 red 8 cycles, blanked 8 cycles, repeating; others 010.
//  - activring=1, bandera=0 -> field pixels alternate 010/110 every 8 cycles; set bandera[1] -> field1 red, blink restarts.

Source files
------------

// File: rtl/vga_campos_texto_pkg.sv
// Shared constants and types for the VGA text-field renderer:
// font character codes, glyph geometry, colours and pipeline metadata.
package vga_campos_texto_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam int CHAR_W  = 7;
  localparam int ROW_W   = 4;
  localparam int ADDR_W  = CHAR_W + ROW_W;

  localparam logic [CHAR_W-1:0] CHR_0     = 7'h30;
  localparam logic [CHAR_W-1:0] CHR_COLON = 7'h3A;
  localparam logic [CHAR_W-1:0] CHR_BLANK = 7'h20;

  localparam logic [2:0] RGB_OFF    = 3'b000;
  localparam logic [2:0] RGB_GREEN  = 3'b010;
  localparam logic [2:0] RGB_RED    = 3'b100;
  localparam logic [2:0] RGB_YELLOW = 3'b110;

  typedef enum logic [1:0] {
    SLOT_TENS  = 2'd0,
    SLOT_UNITS = 2'd1,
    SLOT_SEP   = 2'd2
  } slot_t;

  // Per-pixel attributes that travel alongside the font ROM access.
  typedef struct packed {
    logic [2:0] x;
    logic       vis;
    logic       cur;
    logic       blank;
    logic       ring;
  } pix_meta_t;

  function automatic logic [CHAR_W-1:0] bcd_char(input logic [3:0] d);
    return (d <= 4'd9) ? (CHR_0 + {3'b000, d}) : CHR_BLANK;
  endfunction

endpackage

// File: rtl/vga_campos_texto_parpadeo.sv
// Cursor blink generator: free-running half-period counter and phase bit,
// restarted to a visible phase whenever any cursor flag rises.
module vga_parpadeo #(
  parameter int BLINK_DIV = 25_000_000,
  parameter int N         = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] bandera,
  output logic         phase
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [N-1:0]  bandera_q;
  logic          restart;

  assign restart = |(bandera & ~bandera_q);

  // A restart takes priority over a wrap landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      phase     <= 1'b0;
      bandera_q <= '0;
    end else begin
      bandera_q <= bandera;
      if (restart) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_campos_texto.sv
// Text-row renderer for the VGA clock: NUM_CAMPOS two-digit BCD fields drawn
// from an external sync font ROM through a fixed 3-cycle pixel pipeline.
module vga_campos_texto
  import vga_campos_texto_pkg::*;
#(
  parameter int         NUM_CAMPOS = 9,
  parameter int         ORIGEN_X   = 64,
  parameter int         ORIGEN_Y   = 128,
  parameter int         BLINK_DIV  = 25_000_000,
  parameter logic [2:0] COLOR_NORM = RGB_GREEN,
  parameter logic [2:0] COLOR_CUR  = RGB_RED,
  parameter logic [2:0] COLOR_RING = RGB_YELLOW
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    video_on,
  input  logic [9:0]              pixel_x,
  input  logic [9:0]              pixel_y,
  input  logic                    h_sync_in,
  input  logic                    v_sync_in,
  input  logic [8*NUM_CAMPOS-1:0] digitos,
  input  logic [NUM_CAMPOS-1:0]   bandera,
  input  logic                    activring,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [7:0]              rom_data,
  output logic                    h_sync,
  output logic                    v_sync,
  output logic                    text_on,
  output logic [2:0]              text_rgb
);

  generate
    if (ORIGEN_X % GLYPH_W != 0) begin : g_bad_origen_x
      $error("vga_campos_texto: ORIGEN_X must be a multiple of 8");
    end
    if (NUM_CAMPOS < 1 || NUM_CAMPOS > 16) begin : g_bad_num_campos
      $error("vga_campos_texto: NUM_CAMPOS must be in 1..16");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
      $error("vga_campos_texto: BLINK_DIV must be at least 2");
    end
  endgenerate

  localparam logic [10:0] X_LO = 11'(ORIGEN_X);
  localparam logic [10:0] X_HI = 11'(ORIGEN_X + 3 * GLYPH_W * NUM_CAMPOS);
  localparam logic [10:0] Y_LO = 11'(ORIGEN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGEN_Y + GLYPH_H);

  logic              phase;
  logic [9:0]        rel_x;
  logic [6:0]        col;
  logic [ROW_W-1:0]  glyph_row;
  logic              in_region;
  slot_t             slot;
  logic [3:0]        tens;
  logic [3:0]        units;
  logic              cur_flag;
  logic              is_last;
  logic [CHAR_W-1:0] char_code;
  pix_meta_t         s1;
  pix_meta_t         s2;
  logic              pixel_bit;
  logic              lit;
  logic [2:0]        hs_d;
  logic [2:0]        vs_d;

  vga_parpadeo #(
    .BLINK_DIV (BLINK_DIV),
    .N         (NUM_CAMPOS)
  ) u_parpadeo (
    .clk     (CLK),
    .reset   (RESET),
    .bandera (bandera),
    .phase   (phase)
  );

  assign rel_x     = pixel_x - X_LO[9:0];
  assign col       = rel_x[9:3];
  assign glyph_row = pixel_y[3:0] - Y_LO[3:0];
  assign in_region = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                     ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);

  // Field/slot decode by range compare against each field's 3-cell window.
  always_comb begin
    slot     = SLOT_TENS;
    tens     = 4'd0;
    units    = 4'd0;
    cur_flag = 1'b0;
    is_last  = 1'b0;
    for (int i = 0; i < NUM_CAMPOS; i++) begin
      if (col >= 7'(3 * i) && col < 7'(3 * i + 3)) begin
        slot     = slot_t'(2'(col - 7'(3 * i)));
        tens     = digitos[8*i+4 +: 4];
        units    = digitos[8*i +: 4];
        cur_flag = bandera[i] & in_region;
        is_last  = (i == NUM_CAMPOS - 1);
      end
    end
  end

  always_comb begin
    char_code = CHR_BLANK;
    case (slot)
      SLOT_TENS:  char_code = bcd_char(tens);
      SLOT_UNITS: char_code = bcd_char(units);
      SLOT_SEP:   char_code = is_last ? CHR_BLANK : CHR_COLON;
      default:    char_code = CHR_BLANK;
    endcase
  end

  // Stage 1 issues the ROM read; stage 2 waits for the ROM; stage 3 resolves colour.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rom_addr <= '0;
      s1       <= '0;
      s2       <= '0;
      text_on  <= 1'b0;
      text_rgb <= RGB_OFF;
    end else begin
      rom_addr <= {char_code, glyph_row};
      s1.x     <= rel_x[2:0];
      s1.vis   <= video_on & in_region;
      s1.cur   <= cur_flag;
      s1.blank <= cur_flag & phase;
      s1.ring  <= activring & phase;
      s2       <= s1;
      text_on  <= lit;
      if (!lit)
        text_rgb <= RGB_OFF;
      else if (s2.cur)
        text_rgb <= COLOR_CUR;
      else if (s2.ring)
        text_rgb <= COLOR_RING;
      else
        text_rgb <= COLOR_NORM;
    end
  end

  assign pixel_bit = rom_data[3'd7 - s2.x];
  assign lit       = s2.vis & pixel_bit & ~s2.blank;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hs_d <= '1;
      vs_d <= '1;
    end else begin
      hs_d <= {hs_d[1:0], h_sync_in};
      vs_d <= {vs_d[1:0], v_sync_in};
    end
  end

  assign h_sync = hs_d[2];
  assign v_sync = vs_d[2];

endmodule

// File: tb/tb_vga_campos_texto.sv
// Self-checking bench for vga_campos_texto: directed and randomized pixels
// compared against a cycle-indexed behavioural model of the text row.
module tb_vga_campos_texto;

  localparam int NC   = 3;
  localparam int DIV  = 8;
  localparam int OX   = 64;
  localparam int OY   = 128;
  localparam int MAXC = 8192;

  logic          CLK;
  logic          RESET;
  logic          video_on;
  logic [9:0]    pixel_x;
  logic [9:0]    pixel_y;
  logic          h_sync_in;
  logic          v_sync_in;
  logic [8*NC-1:0] digitos;
  logic [NC-1:0] bandera;
  logic          activring;
  logic [10:0]   rom_addr;
  logic [7:0]    rom_data;
  logic          h_sync;
  logic          v_sync;
  logic          text_on;
  logic [2:0]    text_rgb;

  int n_checks = 0;
  int n_fail   = 0;

  vga_campos_texto #(
    .NUM_CAMPOS (NC),
    .ORIGEN_X   (OX),
    .ORIGEN_Y   (OY),
    .BLINK_DIV  (DIV),
    .COLOR_NORM (3'b010),
    .COLOR_CUR  (3'b100),
    .COLOR_RING (3'b110)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .h_sync_in (h_sync_in),
    .v_sync_in (v_sync_in),
    .digitos   (digitos),
    .bandera   (bandera),
    .activring (activring),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .h_sync    (h_sync),
    .v_sync    (v_sync),
    .text_on   (text_on),
    .text_rgb  (text_rgb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Font ROM stand-in: '8' fully lit, blank empty, everything else a varied pattern.
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    if (a[10:4] == 7'h38) return 8'hFF;
    if (a[10:4] == 7'h20) return 8'h00;
    return 8'(int'(a) * 37 + 27);
  endfunction

  always @(posedge CLK) rom_data <= rom_fn(rom_addr);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference: what a pixel should look like from the field/glyph rules alone.
  task automatic model_pixel(input int xi, input int yi, input logic vid,
                             input logic [8*NC-1:0] dig, input logic [NC-1:0] band,
                             input logic ring, input logic ph,
                             output logic [3:0] pix, output logic [10:0] addr,
                             output logic inreg);
    int col, f, s, row, tn, un, code;
    logic [7:0] g;
    logic b, cur, on;
    logic [2:0] rgb;
    inreg = (xi >= OX) && (xi < OX + 24 * NC) && (yi >= OY) && (yi < OY + 16);
    pix  = 4'd0;
    addr = 11'd0;
    if (inreg) begin
      col  = (xi - OX) / 8;
      f    = col / 3;
      s    = col % 3;
      row  = (yi - OY) % 16;
      tn   = int'((dig >> (8 * f + 4)) & 24'hF);
      un   = int'((dig >> (8 * f)) & 24'hF);
      if (s == 0)      code = (tn <= 9) ? 48 + tn : 32;
      else if (s == 1) code = (un <= 9) ? 48 + un : 32;
      else             code = (f == NC - 1) ? 32 : 58;
      addr = 11'(code * 16 + row);
      g    = rom_fn(addr);
      b    = g[7 - (xi % 8)];
      cur  = band[f];
      on   = vid && b && !(cur && ph);
      if (!on)              rgb = 3'b000;
      else if (cur)         rgb = 3'b100;
      else if (ring && ph)  rgb = 3'b110;
      else                  rgb = 3'b010;
      pix = {on, rgb};
    end
  endtask

  logic [5:0]    exp_pix  [MAXC];
  logic [10:0]   exp_addr [MAXC];
  logic          chk_addr [MAXC];
  logic          rst_at   [MAXC];
  int            cyc = 0;
  int            t_since = 0;
  logic [NC-1:0] prev_band = '0;

  // Record expectations at each edge, check the registered outputs half a cycle later.
  always begin
    logic [3:0]  pix;
    logic [10:0] addr;
    logic        inreg;
    logic        ph;
    logic        any_rst;
    int          idx;
    @(posedge CLK);
    ph = ((t_since / DIV) % 2) == 1;
    model_pixel(int'(pixel_x), int'(pixel_y), video_on, digitos, bandera, activring, ph,
                pix, addr, inreg);
    idx = cyc;
    if (idx < MAXC) begin
      exp_pix[idx]  = {pix, h_sync_in, v_sync_in};
      exp_addr[idx] = addr;
      chk_addr[idx] = inreg;
      rst_at[idx]   = RESET;
    end
    if (RESET) begin
      t_since   = 0;
      prev_band = '0;
    end else begin
      if (|(bandera & ~prev_band)) t_since = 0;
      else t_since++;
      prev_band = bandera;
    end
    cyc++;
    @(negedge CLK);
    if (idx < MAXC) begin
      if (rst_at[idx])
        checkOutput("rom_addr_reset", 32'(rom_addr), 32'd0);
      else if (chk_addr[idx])
        checkOutput("rom_addr", 32'(rom_addr), 32'(exp_addr[idx]));
      any_rst = rst_at[idx];
      if (idx >= 1) any_rst = any_rst | rst_at[idx-1];
      if (idx >= 2) any_rst = any_rst | rst_at[idx-2];
      if (any_rst)
        checkOutput("reset_outputs", 32'({text_on, text_rgb, h_sync, v_sync}), 32'(6'b000011));
      else if (idx >= 2)
        checkOutput("pixel", 32'({text_on, text_rgb, h_sync, v_sync}), 32'(exp_pix[idx-2]));
    end
  end

  task automatic applyStimulus(input logic r, input logic [9:0] x, input logic [9:0] y,
                               input logic vid);
    @(negedge CLK);
    RESET     = r;
    pixel_x   = x;
    pixel_y   = y;
    video_on  = vid;
    h_sync_in = 1'($urandom_range(0, 1));
    v_sync_in = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [8*NC-1:0] rand_digits();
    logic [8*NC-1:0] d;
    for (int i = 0; i < 2 * NC; i++) d[4*i +: 4] = 4'($urandom_range(0, 11));
    return d;
  endfunction

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 49) == 0) digitos = rand_digits();
      if ($urandom_range(0, 39) == 0) bandera = NC'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) activring = ~activring;
      applyStimulus(1'b0, 10'($urandom_range(56, 144)), 10'($urandom_range(124, 148)),
                    $urandom_range(0, 9) != 0);
    end
  endtask

  initial begin
    RESET     = 1'b1;
    video_on  = 1'b0;
    pixel_x   = '0;
    pixel_y   = '0;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    digitos   = '0;
    bandera   = '0;
    activring = 1'b0;

    applyStimulus(1'b1, 10'd0, 10'd0, 1'b0);
    digitos = 24'h000088;
    for (int x = 64; x <= 71; x++) applyStimulus(1'b0, 10'(x), 10'd130, 1'b1);
    applyStimulus(1'b0, 10'd63, 10'd130, 1'b1);
    applyStimulus(1'b0, 10'd136, 10'd130, 1'b1);
    applyStimulus(1'b0, 10'd64, 10'd144, 1'b1);
    applyStimulus(1'b0, 10'd80, 10'd128, 1'b1);
    applyStimulus(1'b0, 10'd66, 10'd130, 1'b0);

    digitos = 24'h93C75A;
    for (int r = 0; r < 3; r++)
      for (int x = 60; x <= 140; x++)
        applyStimulus(1'b0, 10'(x), 10'(128 + 7 * r + (r == 2 ? 1 : 0)), 1'b1);

    random_cycles(800);

    digitos   = 24'h885888;
    bandera   = '0;
    activring = 1'b0;
    applyStimulus(1'b0, 10'd64, 10'd131, 1'b1);
    bandera = 3'b001;
    for (int i = 0; i < 48; i++) applyStimulus(1'b0, 10'(64 + (i % 24)), 10'd131, 1'b1);
    bandera   = 3'b000;
    activring = 1'b1;
    for (int i = 0; i < 48; i++) applyStimulus(1'b0, 10'(64 + (i % 72)), 10'd131, 1'b1);
    bandera = 3'b010;
    for (int i = 0; i < 48; i++) applyStimulus(1'b0, 10'(64 + (i % 72)), 10'd131, 1'b1);
    activring = 1'b0;
    bandera   = 3'b000;

    random_cycles(10);
    applyStimulus(1'b1, 10'd70, 10'd130, 1'b1);
    random_cycles(20);

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 10'd0, 10'd0, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
